// File: rtl/decode_queue_if.sv
// Fetch/issue handshake bundle for decode_queue. The slave modport is the queue side.
// out_op / out_alufunc carry decode_pkg::decode_op_t / alufunc_t encodings.
interface decode_queue_if #(
  parameter int PC_WIDTH = 64
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [PC_WIDTH-1:0] in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_instr;
  logic [PC_WIDTH-1:0] out_pc;
  logic [3:0]          out_op;
  logic [4:0]          out_alufunc;
  logic                out_regwrite;
  logic                out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_op, out_alufunc,
           out_regwrite, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_op, out_alufunc,
           out_regwrite, out_illegal
  );
endinterface

// File: rtl/decode_queue.sv
// Buffered RV64I(+M) decode stage: decode on entry, DEPTH-entry circular queue to issue.
// Define DECODE_RVM_EN to decode the funct7=0000001 M-extension set on OP/OP-32.
package decode_pkg;
  typedef enum logic [3:0] {
    OP_ALUI, OP_ALU, OP_ALUIW, OP_ALUW, OP_LUI, OP_AUIPC,
    OP_JAL, OP_JALR, OP_LD, OP_SD, OP_BZ, OP_BNZ
  } decode_op_t;

  typedef enum logic [4:0] {
    AF_ADD, AF_SUB, AF_XOR, AF_OR, AF_AND, AF_SLT, AF_SLTU, AF_SLL, AF_SRL,
    AF_SRA, AF_CPYB, AF_EQL, AF_MULT, AF_DIV, AF_DIVU, AF_REM, AF_REMU
  } alufunc_t;
endpackage

module decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  decode_queue_if.slave              bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

`ifdef DECODE_RVM_EN
  localparam logic RVM_EN = 1'b1;
`else
  localparam logic RVM_EN = 1'b0;
`endif

  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;

  logic [PW-1:0]       r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]       r_count;
  logic [31:0]         r_instr    [DEPTH];
  logic [PC_WIDTH-1:0] r_pc       [DEPTH];
  decode_op_t          r_op       [DEPTH];
  alufunc_t            r_alufunc  [DEPTH];
  logic                r_regwrite [DEPTH];
  logic                r_illegal  [DEPTH];

  logic [6:0] w_opcode, w_f7;
  logic [2:0] w_f3;
  logic       w_shift_f3, w_shift6_ok, w_shift5_ok, w_m_f3_ok;
  decode_op_t w_op;
  alufunc_t   w_alufunc;
  logic       w_regwrite, w_illegal;
  logic       w_in_ready, w_out_valid, w_enq, w_deq;

  // OP/OP-IMM funct3 map; f3=101 selects SRA when arith is set.
  function automatic alufunc_t base_func(input logic [2:0] f3, input logic arith);
    case (f3)
      3'b000:  return AF_ADD;
      3'b001:  return AF_SLL;
      3'b010:  return AF_SLT;
      3'b011:  return AF_SLTU;
      3'b100:  return AF_XOR;
      3'b101:  return arith ? AF_SRA : AF_SRL;
      3'b110:  return AF_OR;
      default: return AF_AND;
    endcase
  endfunction

  function automatic alufunc_t m_func(input logic [2:0] f3);
    case (f3)
      3'b000:  return AF_MULT;
      3'b100:  return AF_DIV;
      3'b101:  return AF_DIVU;
      3'b110:  return AF_REM;
      default: return AF_REMU;
    endcase
  endfunction

  assign w_opcode    = bus.in_instr[6:0];
  assign w_f3        = bus.in_instr[14:12];
  assign w_f7        = bus.in_instr[31:25];
  assign w_shift_f3  = (w_f3 == 3'b001) || (w_f3 == 3'b101);
  assign w_shift6_ok = (bus.in_instr[31:26] == 6'b000000) || (bus.in_instr[31:26] == 6'b010000);
  assign w_shift5_ok = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
  assign w_m_f3_ok   = (w_f3 == 3'b000) || w_f3[2];

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    w_op       = OP_ALUI;
    w_alufunc  = AF_ADD;
    w_regwrite = 1'b1;
    w_illegal  = 1'b0;
    case (w_opcode)
      OPC_OPIMM: begin
        w_alufunc = base_func(w_f3, bus.in_instr[30]);
        w_illegal = w_shift_f3 && !w_shift6_ok;
      end
      OPC_OP, OPC_OP32: begin
        w_op = (w_opcode == OPC_OP) ? OP_ALU : OP_ALUW;
        if (w_f7 == 7'b0000000) begin
          w_alufunc = base_func(w_f3, 1'b0);
          w_illegal = (w_opcode == OPC_OP32) && !(w_f3 == 3'b000 || w_shift_f3);
        end else if (w_f7 == 7'b0100000) begin
          w_alufunc = w_f3[2] ? AF_SRA : AF_SUB;
          w_illegal = !(w_f3 == 3'b000 || w_f3 == 3'b101);
        end else if (RVM_EN && w_f7 == 7'b0000001) begin
          w_alufunc = m_func(w_f3);
          w_illegal = !w_m_f3_ok;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OPC_OPIMM32: begin
        w_op      = OP_ALUIW;
        w_alufunc = base_func(w_f3, bus.in_instr[30]);
        w_illegal = !(w_f3 == 3'b000 || (w_shift_f3 && w_shift5_ok));
      end
      OPC_LUI: begin
        w_op      = OP_LUI;
        w_alufunc = AF_CPYB;
      end
      OPC_AUIPC: w_op = OP_AUIPC;
      OPC_JAL:   w_op = OP_JAL;
      OPC_JALR: begin
        w_op      = OP_JALR;
        w_illegal = (w_f3 != 3'b000);
      end
      OPC_LOAD:  w_op = OP_LD;
      OPC_STORE: begin
        w_op       = OP_SD;
        w_regwrite = 1'b0;
      end
      OPC_BRANCH: begin
        w_op       = w_f3[0] ? OP_BNZ : OP_BZ;
        w_regwrite = 1'b0;
        case (w_f3[2:1])
          2'b00:   w_alufunc = AF_EQL;
          2'b10:   w_alufunc = AF_SLT;
          2'b11:   w_alufunc = AF_SLTU;
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
    // Illegal encodings travel in order as a harmless non-writing ALUI/ADD.
    if (w_illegal) begin
      w_op       = OP_ALUI;
      w_alufunc  = AF_ADD;
      w_regwrite = 1'b0;
    end
  end

  // A full queue refuses input even when the head drains in the same cycle.
  assign w_in_ready  = (r_count < CW'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_enq       = bus.in_valid && w_in_ready && !flush;
  assign w_deq       = w_out_valid && bus.out_ready && !flush;

  // NOTE: sequential state uses non-blocking assignments; the storage array is reset
  // too, so out_* read as zero straight out of reset rather than as X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i]    <= '0;
        r_pc[i]       <= '0;
        r_op[i]       <= OP_ALUI;
        r_alufunc[i]  <= AF_ADD;
        r_regwrite[i] <= 1'b0;
        r_illegal[i]  <= 1'b0;
      end
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_instr[r_wr_ptr]    <= bus.in_instr;
        r_pc[r_wr_ptr]       <= bus.in_pc;
        r_op[r_wr_ptr]       <= w_op;
        r_alufunc[r_wr_ptr]  <= w_alufunc;
        r_regwrite[r_wr_ptr] <= w_regwrite;
        r_illegal[r_wr_ptr]  <= w_illegal;
        r_wr_ptr             <= r_wr_ptr + PW'(1);
      end
      if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count            = r_count;
  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_instr    = r_instr[r_rd_ptr];
  assign bus.out_pc       = r_pc[r_rd_ptr];
  assign bus.out_op       = r_op[r_rd_ptr];
  assign bus.out_alufunc  = r_alufunc[r_rd_ptr];
  assign bus.out_regwrite = r_regwrite[r_rd_ptr];
  assign bus.out_illegal  = r_illegal[r_rd_ptr];
endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: decode vector table plus queue corner sequences,
// with a scoreboard queue of expected entries in issue order.
module tb_decode_queue;
  import decode_pkg::*;

  localparam int DEPTH  = 4;
  localparam int NVEC   = 28;

  typedef struct {
    logic [31:0] instr;
    decode_op_t  op;
    alufunc_t    af;
    logic        rw;
    logic        ill;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [63:0] pc;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [2:0] count;

  decode_queue_if #(.PC_WIDTH(64)) bus ();

  decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .count (count),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  sb_t         sb[$];
  vec_t        vecs[NVEC];
  vec_t        cur;
  logic [63:0] cur_pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t ok(input logic [31:0] i, input decode_op_t op, input alufunc_t af,
                              input logic rw);
    return '{i, op, af, rw, 1'b0};
  endfunction

  function automatic vec_t ill(input logic [31:0] i);
    return '{i, OP_ALUI, AF_ADD, 1'b0, 1'b1};
  endfunction

  task automatic drive(input logic valid, input vec_t v, input logic [63:0] pc);
    bus.in_valid = valid;
    bus.in_instr = v.instr;
    bus.in_pc    = pc;
    cur          = v;
    cur_pc       = pc;
  endtask

  // Checks occupancy flags at the negedge, then retires/accepts against the model.
  task automatic step();
    int  sz;
    sb_t e;
    @(negedge clk);
    sz = sb.size();
    check("count", 64'(count), 64'(sz));
    check("out_valid", 64'(bus.out_valid), 64'(sz != 0));
    check("in_ready", 64'(bus.in_ready), 64'(sz < DEPTH));
    if (flush) begin
      sb.delete();
    end else begin
      if (sz != 0 && bus.out_ready) begin
        e = sb.pop_front();
        check("out_pc", bus.out_pc, e.pc);
        check("decode{instr,op,af,rw,ill}",
              64'({bus.out_instr, bus.out_op, bus.out_alufunc, bus.out_regwrite, bus.out_illegal}),
              64'({e.v.instr, e.v.op, e.v.af, e.v.rw, e.v.ill}));
      end
      if (bus.in_valid && sz < DEPTH) sb.push_back('{cur, cur_pc});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = ok(32'h00a00093, OP_ALUI,  AF_ADD,  1'b1);
    vecs[1]  = ok(32'h4000d0b3, OP_ALU,   AF_SRA,  1'b1);
    vecs[2]  = ok(32'h0000a0b3, OP_ALU,   AF_SLT,  1'b1);
    vecs[3]  = ill(32'h40002033);
    vecs[4]  = ill(32'h0000a063);
`ifdef DECODE_RVM_EN
    vecs[5]  = ok(32'h02b50533, OP_ALU,   AF_MULT, 1'b1);
    vecs[23] = ok(32'h0220c0bb, OP_ALUW,  AF_DIV,  1'b1);
`else
    vecs[5]  = ill(32'h02b50533);
    vecs[23] = ill(32'h0220c0bb);
`endif
    vecs[6]  = ill(32'hffffffff);
    vecs[7]  = ok(32'h123450b7, OP_LUI,   AF_CPYB, 1'b1);
    vecs[8]  = ok(32'h00000097, OP_AUIPC, AF_ADD,  1'b1);
    vecs[9]  = ok(32'h008000ef, OP_JAL,   AF_ADD,  1'b1);
    vecs[10] = ok(32'h00008067, OP_JALR,  AF_ADD,  1'b1);
    vecs[11] = ill(32'h00009067);
    vecs[12] = ok(32'h00013083, OP_LD,    AF_ADD,  1'b1);
    vecs[13] = ok(32'h00113023, OP_SD,    AF_ADD,  1'b0);
    vecs[14] = ok(32'h00000063, OP_BZ,    AF_EQL,  1'b0);
    vecs[15] = ok(32'h00001063, OP_BNZ,   AF_EQL,  1'b0);
    vecs[16] = ok(32'h00004063, OP_BZ,    AF_SLT,  1'b0);
    vecs[17] = ok(32'h00007063, OP_BNZ,   AF_SLTU, 1'b0);
    vecs[18] = ok(32'h4030d093, OP_ALUI,  AF_SRA,  1'b1);
    vecs[19] = ill(32'h80001093);
    vecs[20] = ok(32'h0010809b, OP_ALUIW, AF_ADD,  1'b1);
    vecs[21] = ill(32'h0010a09b);
    vecs[22] = ok(32'h402080bb, OP_ALUW,  AF_SUB,  1'b1);
    vecs[24] = ill(32'h022090bb);
    vecs[25] = ok(32'h0020c0b3, OP_ALU,   AF_XOR,  1'b1);
    vecs[26] = ok(32'h4030d09b, OP_ALUIW, AF_SRA,  1'b1);
    vecs[27] = ill(32'h0230909b);

    reset = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, vecs[0], 64'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state: empty, ready, head fields zero.
    @(negedge clk);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    check("rst count", 64'(count), 64'd0);
    check("rst out_instr", 64'(bus.out_instr), 64'd0);
    check("rst out_pc", bus.out_pc, 64'd0);
    check("rst out_op/af/rw/ill",
          64'({bus.out_op, bus.out_alufunc, bus.out_regwrite, bus.out_illegal}), 64'd0);
    @(posedge clk);
    #1;

    // Single addi: not visible in the enqueue cycle, visible the next.
    drive(1'b1, vecs[0], 64'h8000_0000);
    step();
    drive(1'b0, vecs[0], 64'h0);
    bus.out_ready = 1'b1;
    step();

    // Decode table streamed through with issue always ready.
    for (int i = 0; i < NVEC; i++) begin
      drive(1'b1, vecs[i], 64'h1000 + 64'(4 * i));
      step();
    end
    drive(1'b0, vecs[0], 64'h0);
    repeat (2) step();

    // Fill to DEPTH with issue stalled; the extra push must be dropped.
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1'b1, vecs[i], 64'h2000 + 64'(4 * i));
      step();
    end
    // Concurrent enqueue/dequeue long enough to wrap both pointers twice.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      drive(1'b1, vecs[i + 5], 64'h3000 + 64'(4 * i));
      step();
    end
    drive(1'b0, vecs[0], 64'h0);
    repeat (DEPTH + 1) step();

    // Flush with three queued plus a push and a dequeue in the same cycle.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vecs[i + 7], 64'h4000 + 64'(4 * i));
      step();
    end
    flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, vecs[12], 64'hdead_0000);
    step();
    flush = 1'b0;
    drive(1'b0, vecs[0], 64'h0);
    repeat (3) step();

    // Asynchronous reset mid-stream with three entries queued.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vecs[i + 14], 64'h5000 + 64'(4 * i));
      step();
    end
    drive(1'b0, vecs[0], 64'h0);
    #2 reset = 1'b1;
    #1;
    check("async rst out_valid", 64'(bus.out_valid), 64'd0);
    check("async rst count", 64'(count), 64'd0);
    check("async rst in_ready", 64'(bus.in_ready), 64'd1);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    step();

    // Queue usable again after reset.
    bus.out_ready = 1'b1;
    drive(1'b1, vecs[18], 64'h6000);
    step();
    drive(1'b0, vecs[0], 64'h0);
    repeat (2) step();
    check("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
